// File: rtl/max7219_rx.sv
// MAX7219-compatible serial receiver: oversamples CLK/DIN/LOAD, shifts 16-bit frames,
// commits them on LOAD rise into a MAX7219 register file and forwards bits on DOUT.
module max7219_rx (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_serial_clk,
    input  logic       i_serial_din,
    input  logic       i_serial_load,
    output logic       o_serial_dout,
    output logic       o_wr_stb,
    output logic [3:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    output logic       o_frame_err,
    input  logic [2:0] i_rd_addr,
    output logic [7:0] o_rd_data,
    output logic [7:0] o_decode_mode,
    output logic [3:0] o_intensity,
    output logic [2:0] o_scan_limit,
    output logic       o_shutdown_n,
    output logic       o_display_test
);

    logic [2:0]  sclk_sync_q, sclk_sync_d;
    logic [2:0]  load_sync_q, load_sync_d;
    logic [1:0]  din_sync_q, din_sync_d;
    logic [15:0] shift_q, shift_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        dout_q, dout_d;
    logic        wr_stb_q, wr_stb_d;
    logic        frame_err_q, frame_err_d;
    logic [3:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [7:0]  digit_q [8];
    logic [7:0]  digit_d [8];
    logic [7:0]  decode_q, decode_d;
    logic [3:0]  intensity_q, intensity_d;
    logic [2:0]  scan_q, scan_d;
    logic        shutdown_n_q, shutdown_n_d;
    logic        test_q, test_d;

    logic sclk_rise, sclk_fall, load_rise;

    // Bit 1 is the synchronized level, bit 2 its previous value.
    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign load_rise = load_sync_q[1] & ~load_sync_q[2];

    always_comb begin
        sclk_sync_d  = {sclk_sync_q[1:0], i_serial_clk};
        load_sync_d  = {load_sync_q[1:0], i_serial_load};
        din_sync_d   = {din_sync_q[0], i_serial_din};
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        dout_d       = dout_q;
        wr_stb_d     = 1'b0;
        frame_err_d  = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        digit_d      = digit_q;
        decode_d     = decode_q;
        intensity_d  = intensity_q;
        scan_d       = scan_q;
        shutdown_n_d = shutdown_n_q;
        test_d       = test_q;

        if (sclk_rise) begin
            shift_d   = {shift_q[14:0], din_sync_q[1]};
            bit_cnt_d = (bit_cnt_q == 5'd16) ? 5'd16 : bit_cnt_q + 5'd1;
        end
        if (sclk_fall) begin
            dout_d = shift_q[15];
        end

        // Commit sees the post-shift frame when CLK and LOAD edges coincide.
        if (load_rise) begin
            if (bit_cnt_d == 5'd16) begin
                wr_stb_d  = 1'b1;
                wr_addr_d = shift_d[11:8];
                wr_data_d = shift_d[7:0];
                case (shift_d[11:8])
                    4'h1, 4'h2, 4'h3, 4'h4,
                    4'h5, 4'h6, 4'h7, 4'h8: digit_d[shift_d[10:8] - 3'd1] = shift_d[7:0];
                    4'h9:    decode_d     = shift_d[7:0];
                    4'hA:    intensity_d  = shift_d[3:0];
                    4'hB:    scan_d       = shift_d[2:0];
                    4'hC:    shutdown_n_d = shift_d[0];
                    4'hF:    test_d       = shift_d[0];
                    default: ;
                endcase
            end else begin
                frame_err_d = 1'b1;
            end
            bit_cnt_d = 5'd0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            sclk_sync_q  <= '0;
            load_sync_q  <= '0;
            din_sync_q   <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            dout_q       <= 1'b0;
            wr_stb_q     <= 1'b0;
            frame_err_q  <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            for (int i = 0; i < 8; i++) digit_q[i] <= '0;
            decode_q     <= '0;
            intensity_q  <= '0;
            scan_q       <= '0;
            shutdown_n_q <= 1'b0;
            test_q       <= 1'b0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            load_sync_q  <= load_sync_d;
            din_sync_q   <= din_sync_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            dout_q       <= dout_d;
            wr_stb_q     <= wr_stb_d;
            frame_err_q  <= frame_err_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            digit_q      <= digit_d;
            decode_q     <= decode_d;
            intensity_q  <= intensity_d;
            scan_q       <= scan_d;
            shutdown_n_q <= shutdown_n_d;
            test_q       <= test_d;
        end
    end

    assign o_serial_dout  = dout_q;
    assign o_wr_stb       = wr_stb_q;
    assign o_wr_addr      = wr_addr_q;
    assign o_wr_data      = wr_data_q;
    assign o_frame_err    = frame_err_q;
    assign o_rd_data      = digit_q[i_rd_addr];
    assign o_decode_mode  = decode_q;
    assign o_intensity    = intensity_q;
    assign o_scan_limit   = scan_q;
    assign o_shutdown_n   = shutdown_n_q;
    assign o_display_test = test_q;

endmodule

// File: tb/tb_max7219_rx.sv
// Directed bench for max7219_rx: expected commits queued at LOAD, checked by a pulse monitor.
module tb_max7219_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       sdin = 1'b0;
    logic       sload = 1'b0;
    logic       dout;
    logic       wr_stb;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_err;
    logic [2:0] rd_addr = 3'd0;
    logic [7:0] rd_data;
    logic [7:0] decode_mode;
    logic [3:0] intensity;
    logic [2:0] scan_limit;
    logic       shutdown_n;
    logic       display_test;

    always #10 clk = ~clk;

    max7219_rx dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_serial_clk   (sclk),
        .i_serial_din   (sdin),
        .i_serial_load  (sload),
        .o_serial_dout  (dout),
        .o_wr_stb       (wr_stb),
        .o_wr_addr      (wr_addr),
        .o_wr_data      (wr_data),
        .o_frame_err    (frame_err),
        .i_rd_addr      (rd_addr),
        .o_rd_data      (rd_data),
        .o_decode_mode  (decode_mode),
        .o_intensity    (intensity),
        .o_scan_limit   (scan_limit),
        .o_shutdown_n   (shutdown_n),
        .o_display_test (display_test)
    );

    typedef struct packed {
        logic       err;
        logic [3:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errs = 0;
    logic [31:0] dout_hist = '0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Every strobe or error pulse must match the oldest queued commit.
    always @(negedge clk) begin
        if (wr_stb || frame_err) begin
            if (exp_q.size() == 0) begin
                chk("spurious_pulse", {14'd0, frame_err, wr_stb}, 16'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_kind", {14'd0, frame_err, wr_stb}, e.err ? 16'h2 : 16'h1);
                if (!e.err) begin
                    chk("wr_addr", {12'd0, wr_addr}, {12'd0, e.addr});
                    chk("wr_data", {8'd0, wr_data}, {8'd0, e.data});
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] word, input int nbits, input int half);
        for (int i = nbits - 1; i >= 0; i--) begin
            sdin = word[i];
            tick(half);
            sclk = 1'b1;
            tick(half);
            dout_hist = {dout_hist[30:0], dout};
            sclk = 1'b0;
        end
    endtask

    task automatic load_pulse(input logic err, input logic [15:0] frame);
        exp_t e;
        e.err  = err;
        e.addr = frame[11:8];
        e.data = frame[7:0];
        exp_q.push_back(e);
        tick(3);
        sload = 1'b1;
        tick(3);
        sload = 1'b0;
        tick(3);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick(1);
        chk(name, 16'(exp_q.size()), 16'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        tick(1);
        do_reset();
        // 1: reset state
        chk("rst_dout", {15'd0, dout}, 16'h0);
        chk("rst_wr_addr", {12'd0, wr_addr}, 16'h0);
        chk("rst_wr_data", {8'd0, wr_data}, 16'h0);
        chk("rst_cfg", {decode_mode, intensity, scan_limit, display_test}, 16'h0);
        chk("rst_shutdown_n", {15'd0, shutdown_n}, 16'h0);
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            #1;
            chk("rst_rd_data", {8'd0, rd_data}, 16'h0);
        end

        // 2: intensity write
        send(32'h0A07, 16, 4);
        load_pulse(1'b0, 16'h0A07);
        drain("drain_t2");
        chk("intensity_7", {12'd0, intensity}, 16'h7);

        // 3: digit and shutdown writes, serial clock at i_clk/6
        send(32'h035A, 16, 3);
        load_pulse(1'b0, 16'h035A);
        send(32'h0C01, 16, 3);
        load_pulse(1'b0, 16'h0C01);
        drain("drain_t3");
        rd_addr = 3'd2;
        #1;
        chk("digit2_5a", {8'd0, rd_data}, 16'h5A);
        rd_addr = 3'd3;
        #1;
        chk("digit3_zero", {8'd0, rd_data}, 16'h0);
        chk("shutdown_n_1", {15'd0, shutdown_n}, 16'h1);

        // 4: short frame, then full scan-limit frame
        send(32'h00A5, 8, 4);
        load_pulse(1'b1, 16'h0);
        drain("drain_t4a");
        chk("short_intensity", {12'd0, intensity}, 16'h7);
        chk("short_shutdown", {15'd0, shutdown_n}, 16'h1);
        chk("short_scan", {13'd0, scan_limit}, 16'h0);
        send(32'h0B05, 16, 4);
        load_pulse(1'b0, 16'h0B05);
        drain("drain_t4b");
        chk("scan_limit_5", {13'd0, scan_limit}, 16'h5);

        // 5: 32 bits, one LOAD; first frame passes out on DOUT
        send(32'h0F01_0A03, 32, 4);
        load_pulse(1'b0, 16'h0A03);
        drain("drain_t5");
        chk("intensity_3", {12'd0, intensity}, 16'h3);
        chk("display_test_0", {15'd0, display_test}, 16'h0);
        chk("dout_chain", dout_hist[15:0], 16'h0F01);

        // 6: reset mid-frame, error on bare LOAD, then decode and no-op writes
        send(32'h0904 >> 6, 10, 4);
        do_reset();
        chk("rst2_intensity", {12'd0, intensity}, 16'h0);
        chk("rst2_shutdown_n", {15'd0, shutdown_n}, 16'h0);
        rd_addr = 3'd2;
        #1;
        chk("rst2_digit2", {8'd0, rd_data}, 16'h0);
        load_pulse(1'b1, 16'h0);
        drain("drain_t6a");
        send(32'h0904, 16, 4);
        load_pulse(1'b0, 16'h0904);
        drain("drain_t6b");
        chk("decode_mode_4", {8'd0, decode_mode}, 16'h04);
        send(32'h0D55, 16, 4);
        load_pulse(1'b0, 16'h0D55);
        drain("drain_t6c");
        chk("noop_decode", {8'd0, decode_mode}, 16'h04);
        chk("noop_cfg", {intensity, scan_limit, display_test, shutdown_n, 7'd0}, 16'h0);
        chk("noop_digit2", {8'd0, rd_data}, 16'h0);

        tick(10);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
